// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register / ALU block: opcodes, operands and the
// read-side result word.
package instr_register_pkg;

  localparam int OP_W  = 32;
  localparam int RES_W = 2 * OP_W;

  typedef enum logic [2:0] {
    ZERO  = 3'd0,
    PASSA = 3'd1,
    PASSB = 3'd2,
    ADD   = 3'd3,
    SUB   = 3'd4,
    MULT  = 3'd5,
    DIV   = 3'd6,
    MOD   = 3'd7
  } opcode_t;

  typedef logic signed [OP_W-1:0]  operand_t;
  typedef logic signed [RES_W-1:0] result_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } instr_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
    result_t  result;
    logic     written;
    logic     div0;
  } instr_result_t;

endpackage

// File: rtl/instr_register_alu_if.sv
// Write/read bus of the instruction register; master drives requests, slave returns
// the computed instruction word and occupancy.
interface instr_register_alu_if
  import instr_register_pkg::*;
#(
  parameter int DEPTH = 32
) ();
  localparam int AW = $clog2(DEPTH);

  logic          load_en;
  logic [AW-1:0] write_pointer;
  opcode_t       opcode;
  operand_t      operand_a;
  operand_t      operand_b;
  logic          read_en;
  logic [AW-1:0] read_pointer;
  logic          rd_valid;
  instr_result_t instruction_word;
  logic [AW:0]   fill_count;

  modport master (
    output load_en, write_pointer, opcode, operand_a, operand_b, read_en, read_pointer,
    input  rd_valid, instruction_word, fill_count
  );

  modport slave (
    input  load_en, write_pointer, opcode, operand_a, operand_b, read_en, read_pointer,
    output rd_valid, instruction_word, fill_count
  );
endinterface

// File: rtl/instr_register_alu_alu.sv
// Combinational signed ALU; operands are sign-extended to the full result width first
// so products and quotients never truncate.
module instr_alu
  import instr_register_pkg::*;
#(
  parameter int OP_WIDTH = OP_W
) (
  input  opcode_t                      opc_i,
  input  logic signed [OP_WIDTH-1:0]   a_i,
  input  logic signed [OP_WIDTH-1:0]   b_i,
  output logic signed [2*OP_WIDTH-1:0] result_o,
  output logic                         div0_o
);
  localparam int RW = 2 * OP_WIDTH;

  logic signed [RW-1:0] a_ext;
  logic signed [RW-1:0] b_ext;
  logic                 b_zero;

  assign a_ext  = {{OP_WIDTH{a_i[OP_WIDTH-1]}}, a_i};
  assign b_ext  = {{OP_WIDTH{b_i[OP_WIDTH-1]}}, b_i};
  assign b_zero = (b_i == '0);

  always_comb begin
    result_o = '0;
    div0_o   = 1'b0;
    case (opc_i)
      ZERO:  result_o = '0;
      PASSA: result_o = a_ext;
      PASSB: result_o = b_ext;
      ADD:   result_o = a_ext + b_ext;
      SUB:   result_o = a_ext - b_ext;
      MULT:  result_o = a_ext * b_ext;
      // Divide-by-zero reports a flag and a clean zero instead of X.
      DIV: begin
        if (b_zero) div0_o = 1'b1;
        else        result_o = a_ext / b_ext;
      end
      MOD: begin
        if (b_zero) div0_o = 1'b1;
        else        result_o = a_ext % b_ext;
      end
      default: result_o = '0;
    endcase
  end
endmodule

// File: rtl/instr_register_alu.sv
// Instruction register file with a 2-stage read pipeline: stage 1 fetches the entry,
// stage 2 runs the ALU and registers the result word.
module instr_register_alu
  import instr_register_pkg::*;
#(
  parameter int DEPTH    = 32,
  parameter int OP_WIDTH = OP_W
) (
  input logic                 clk,
  input logic                 reset,
  instr_register_alu_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int RW = 2 * OP_WIDTH;

  instr_t         mem_q [DEPTH];
  logic [DEPTH-1:0] written_q;
  logic [AW:0]    fill_count_q;
  logic [AW:0]    fill_count_d;

  logic           s1_valid_q;
  logic           s1_written_q;
  instr_t         s1_instr_q;

  logic           rd_valid_q;
  instr_result_t  word_q;
  instr_result_t  word_d;

  logic signed [RW-1:0] alu_result;
  logic                 alu_div0;

  // Only first writes to a location grow the count, so it saturates at DEPTH.
  always_comb begin
    fill_count_d = fill_count_q;
    if (bus.load_en && !written_q[bus.write_pointer]) fill_count_d = fill_count_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      written_q    <= '0;
      fill_count_q <= '0;
    end else begin
      fill_count_q <= fill_count_d;
      if (bus.load_en) begin
        mem_q[bus.write_pointer]     <= '{opc: bus.opcode, op_a: bus.operand_a, op_b: bus.operand_b};
        written_q[bus.write_pointer] <= 1'b1;
      end
    end
  end

  // Stage 1 samples the pre-write contents, giving read-before-write on collisions.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q   <= 1'b0;
      s1_written_q <= 1'b0;
      s1_instr_q   <= '0;
    end else begin
      s1_valid_q <= bus.read_en;
      if (bus.read_en) begin
        s1_written_q <= written_q[bus.read_pointer];
        if (written_q[bus.read_pointer]) s1_instr_q <= mem_q[bus.read_pointer];
        else                             s1_instr_q <= '0;
      end
    end
  end

  instr_alu #(
    .OP_WIDTH (OP_WIDTH)
  ) u_alu (
    .opc_i    (s1_instr_q.opc),
    .a_i      (s1_instr_q.op_a),
    .b_i      (s1_instr_q.op_b),
    .result_o (alu_result),
    .div0_o   (alu_div0)
  );

  always_comb begin
    word_d         = '0;
    word_d.opc     = s1_instr_q.opc;
    word_d.op_a    = s1_instr_q.op_a;
    word_d.op_b    = s1_instr_q.op_b;
    word_d.result  = alu_result;
    word_d.written = s1_written_q;
    word_d.div0    = alu_div0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      word_q     <= '0;
    end else begin
      rd_valid_q <= s1_valid_q;
      if (s1_valid_q) word_q <= word_d;
    end
  end

  assign bus.rd_valid         = rd_valid_q;
  assign bus.instruction_word = word_q;
  assign bus.fill_count       = fill_count_q;

endmodule

// File: tb/tb_instr_register_alu.sv
// Directed bench for instr_register_alu: inputs change and outputs are sampled on the
// falling clock edge, expected words come from hand-computed tables.
module tb_instr_register_alu;
  import instr_register_pkg::*;

  localparam int DEPTH = 32;
  localparam int AW    = $clog2(DEPTH);

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  instr_register_alu_if #(.DEPTH(DEPTH)) bus ();

  instr_register_alu #(.DEPTH(DEPTH), .OP_WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  opcode_t v_opc [10] = '{ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD, DIV, ADD};
  int      v_a   [10] = '{5, -9, 7, 100, 5, -7, 17, 17, -17, 2147483647};
  int      v_b   [10] = '{3, 4, -12, -30, 20, 6, 5, 5, 5, 1};
  longint  v_res [10] = '{0, -9, -12, 70, -15, -42, 3, 2, -3, 64'sd2147483648};

  function automatic instr_result_t mk(opcode_t opc, int a, int b, longint res, logic wr, logic d0);
    instr_result_t w;
    w.opc     = opc;
    w.op_a    = a;
    w.op_b    = b;
    w.result  = res;
    w.written = wr;
    w.div0    = d0;
    return w;
  endfunction

  task automatic drive_write(input int addr, input opcode_t op, input int a, input int b);
    bus.load_en       = 1'b1;
    bus.write_pointer = AW'(addr);
    bus.opcode        = op;
    bus.operand_a     = a;
    bus.operand_b     = b;
  endtask

  task automatic drive_read(input int addr);
    bus.read_en      = 1'b1;
    bus.read_pointer = AW'(addr);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (bus.rd_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_rd_valid: got %b want 0", bus.rd_valid);
    end
    n_cmp++;
    if (bus.fill_count !== '0) begin
      n_bad++; $display("FAIL reset_fill_count: got %0d want 0", bus.fill_count);
    end
    n_cmp++;
    if (bus.instruction_word !== '0) begin
      n_bad++; $display("FAIL reset_word: got %h want 0", bus.instruction_word);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fill_and_read;
    instr_result_t exp_w;
    for (int i = 0; i < 10; i++) begin
      drive_write(i, v_opc[i], v_a[i], v_b[i]);
      @(negedge clk);
    end
    bus.load_en = 1'b0;
    n_cmp++;
    if (bus.fill_count !== (AW+1)'(10)) begin
      n_bad++; $display("FAIL fill10: got %0d want 10", bus.fill_count);
    end
    for (int k = 0; k < 12; k++) begin
      if (k >= 2) begin
        exp_w = mk(v_opc[k-2], v_a[k-2], v_b[k-2], v_res[k-2], 1'b1, 1'b0);
        n_cmp++;
        if (bus.rd_valid !== 1'b1) begin
          n_bad++; $display("FAIL burst_valid[%0d]: got %b want 1", k-2, bus.rd_valid);
        end
        n_cmp++;
        if (bus.instruction_word !== exp_w) begin
          n_bad++; $display("FAIL burst_word[%0d]: got %h want %h", k-2, bus.instruction_word, exp_w);
        end
      end
      if (k < 10) drive_read(k);
      else        bus.read_en = 1'b0;
      @(negedge clk);
    end
    n_cmp++;
    if (bus.rd_valid !== 1'b0) begin
      n_bad++; $display("FAIL burst_idle_valid: got %b want 0", bus.rd_valid);
    end
  endtask

  task automatic test_mult;
    drive_write(3, MULT, -7, 6);
    @(negedge clk);
    drive_write(4, MULT, 2147483647, 2147483647);
    @(negedge clk);
    bus.load_en = 1'b0;
    n_cmp++;
    if (bus.fill_count !== (AW+1)'(10)) begin
      n_bad++; $display("FAIL rewrite_fill: got %0d want 10", bus.fill_count);
    end
    drive_read(3);
    @(negedge clk);
    drive_read(4);
    @(negedge clk);
    bus.read_en = 1'b0;
    n_cmp++;
    if (bus.instruction_word !== mk(MULT, -7, 6, -42, 1'b1, 1'b0)) begin
      n_bad++; $display("FAIL mult_neg: got %h want result -42", bus.instruction_word);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.instruction_word !== mk(MULT, 2147483647, 2147483647, 64'sh3FFFFFFF00000001, 1'b1, 1'b0)) begin
      n_bad++; $display("FAIL mult_big: got %h want result 3fffffff00000001", bus.instruction_word);
    end
  endtask

  task automatic test_div;
    drive_write(5, DIV, 15, 0);
    @(negedge clk);
    drive_write(6, MOD, -15, 4);
    @(negedge clk);
    bus.load_en = 1'b0;
    drive_read(5);
    @(negedge clk);
    drive_read(6);
    @(negedge clk);
    bus.read_en = 1'b0;
    n_cmp++;
    if (bus.instruction_word !== mk(DIV, 15, 0, 0, 1'b1, 1'b1)) begin
      n_bad++; $display("FAIL div0: got %h want result 0 div0 1", bus.instruction_word);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.instruction_word !== mk(MOD, -15, 4, -3, 1'b1, 1'b0)) begin
      n_bad++; $display("FAIL mod_neg: got %h want result -3 div0 0", bus.instruction_word);
    end
  endtask

  task automatic test_reset_midpipe;
    drive_write(0, ADD, 1, 2);
    @(negedge clk);
    drive_write(1, SUB, 9, 4);
    @(negedge clk);
    bus.load_en = 1'b0;
    drive_read(0);
    @(negedge clk);
    drive_read(1);
    @(negedge clk);
    drive_read(0);
    @(negedge clk);
    // Requests held during reset must be ignored.
    drive_write(9, ADD, 5, 5);
    drive_read(1);
    reset = 1'b1;
    #1;
    n_cmp++;
    if (bus.rd_valid !== 1'b0) begin
      n_bad++; $display("FAIL midreset_async_valid: got %b want 0", bus.rd_valid);
    end
    @(negedge clk);
    reset = 1'b0;
    bus.load_en = 1'b0;
    bus.read_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.rd_valid !== 1'b0) begin
        n_bad++; $display("FAIL midreset_valid[%0d]: got %b want 0", k, bus.rd_valid);
      end
    end
    n_cmp++;
    if (bus.fill_count !== '0) begin
      n_bad++; $display("FAIL midreset_fill: got %0d want 0", bus.fill_count);
    end
    drive_read(0);
    @(negedge clk);
    bus.read_en = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.rd_valid !== 1'b1) begin
      n_bad++; $display("FAIL postreset_valid: got %b want 1", bus.rd_valid);
    end
    n_cmp++;
    if (bus.instruction_word !== '0) begin
      n_bad++; $display("FAIL postreset_word: got %h want 0", bus.instruction_word);
    end
  endtask

  task automatic test_read_before_write;
    drive_write(7, ADD, 3, 4);
    drive_read(7);
    @(negedge clk);
    bus.load_en = 1'b0;
    drive_read(7);
    @(negedge clk);
    bus.read_en = 1'b0;
    n_cmp++;
    if (bus.instruction_word !== mk(ZERO, 0, 0, 0, 1'b0, 1'b0) || bus.rd_valid !== 1'b1) begin
      n_bad++; $display("FAIL rbw_old: got %h valid %b want 0 valid 1", bus.instruction_word, bus.rd_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.instruction_word !== mk(ADD, 3, 4, 7, 1'b1, 1'b0)) begin
      n_bad++; $display("FAIL rbw_new: got %h want ADD 3 4 result 7", bus.instruction_word);
    end
  endtask

  task automatic test_fill_saturate;
    for (int i = 0; i < DEPTH; i++) begin
      drive_write(i, PASSA, i, 0);
      @(negedge clk);
    end
    bus.load_en = 1'b0;
    n_cmp++;
    if (bus.fill_count !== (AW+1)'(DEPTH)) begin
      n_bad++; $display("FAIL fill_full: got %0d want %0d", bus.fill_count, DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) begin
      drive_write(i, PASSB, 0, i);
      @(negedge clk);
      n_cmp++;
      if (bus.fill_count !== (AW+1)'(DEPTH)) begin
        n_bad++; $display("FAIL fill_sat[%0d]: got %0d want %0d", i, bus.fill_count, DEPTH);
      end
    end
    bus.load_en = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset             = 1'b1;
    bus.load_en       = 1'b0;
    bus.write_pointer = '0;
    bus.opcode        = ZERO;
    bus.operand_a     = '0;
    bus.operand_b     = '0;
    bus.read_en       = 1'b0;
    bus.read_pointer  = '0;

    test_reset;
    test_fill_and_read;
    test_mult;
    test_div;
    test_reset_midpipe;
    test_read_before_write;
    test_fill_saturate;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_register_alu.md
INSTR_REGISTER_ALU -- requirements
Module: instr_register_alu

Interface
REQ-001 SHALL have parameter DEPTH, default 32: number of register locations; power of 2, range 2..256.
REQ-002 SHALL have parameter OP_WIDTH, default 32: signed operand width.
REQ-003 SHALL derive AW = $clog2(DEPTH) and RW = 2*OP_WIDTH internally.
REQ-004 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port load_en, input, 1: write strobe.
REQ-007 SHALL have port write_pointer, input, AW: write address.
REQ-008 SHALL have port opcode, input, opcode_t: instruction opcode.
REQ-009 SHALL have ports operand_a and operand_b, input, OP_WIDTH signed each: operands.
REQ-010 SHALL have port read_en, input, 1: read request.
REQ-011 SHALL have port read_pointer, input, AW: read address.
REQ-012 SHALL have port rd_valid, output, 1: instruction_word is valid this cycle.
REQ-013 SHALL have port instruction_word, output, instr_result_t: opc, op_a, op_b, result (RW signed), written, div0.
REQ-014 SHALL have port fill_count, output, AW+1: number of distinct locations written since reset.

Function
REQ-015 SHALL write {opcode, operand_a, operand_b} to location write_pointer on the rising edge when load_en=1, and set that location's written bit.
REQ-016 SHALL increment fill_count only when the written bit of the addressed location was previously 0; rewrites leave it unchanged; maximum value is DEPTH.
REQ-017 SHALL be a 2-stage read pipeline: stage 1 fetches the location and stage 2 computes result; read_en at edge N gives rd_valid=1 with data in the cycle after edge N+2 (latency 2).
REQ-018 SHALL accept one read per cycle with back-to-back reads and no bubbles; rd_valid=0 in every cycle without a matching request.
REQ-019 SHALL compute result by opcode: ZERO=0, PASSA=op_a, PASSB=op_b, ADD=a+b, SUB=a-b, MULT=a*b, DIV=a/b, MOD=a%b; signed arithmetic, sign-extended to RW bits, no truncation.
REQ-020 SHALL, for DIV or MOD with op_b=0, return result=0 and div0=1; div0=0 in all other cases.
REQ-021 SHALL, when a read hits a location with written=0, return opc=ZERO, op_a=0, op_b=0, result=0, written=0.
REQ-022 SHALL, on simultaneous write and read of the same address, return the old contents to the read (read-before-write).
REQ-023 SHALL wrap pointers only by AW-bit truncation; no out-of-range checking is needed.

Reset
REQ-024 SHALL, while reset=1, clear all storage, all written bits, both pipeline stages, fill_count=0, rd_valid=0 and instruction_word=0, independent of clk.
REQ-025 SHALL discard any in-flight reads when reset asserts mid-operation; rd_valid stays 0 until a new read_en arrives after deassertion.
REQ-026 SHALL ignore load_en and read_en during the cycle in which reset is asserted.

Structure
REQ-027 SHALL take opcode_t, operand_t and instr_result_t from the shared package instr_register_pkg; opcode_t enum values are ZERO..MOD = 0..7.
REQ-028 SHALL place the result computation in a single combinational sub-module instr_alu, instanced in stage 2.

Verification
REQ-029 Reset then 10 writes to locations 0..9 then 10 reads -> each read returns its written fields and correct result 2 cycles after read_en; fill_count=10.
REQ-030 Write MULT a=-7 b=6 at loc 3 then read loc 3 -> result=-42 sign-extended; MULT a=2^31-1 b=2^31-1 -> result=(2^31-1)^2 without truncation.
REQ-031 Write DIV a=15 b=0 at loc 5 then read -> result=0, div0=1; MOD a=-15 b=4 -> result=-3, div0=0.
REQ-032 Write loc 7 and read loc 7 in the same cycle, then read again -> first read returns old/unwritten values (written=0); second returns the new values.
REQ-033 Write 2 locations, issue 3 back-to-back reads, assert reset for 1 cycle mid-pipeline -> no rd_valid after reset; fill_count=0; reads return written=0.
REQ-034 Write all DEPTH locations twice -> fill_count saturates at DEPTH and never wraps.
